// File: rtl/ro_meas_sequencer.sv
// Ring-oscillator measurement sequencer: heat-up, gated count window, settle,
// word handshake and cool-down, repeated for the requested number of readouts.
module ro_meas_sequencer #(
   parameter int CNT_WIDTH     = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   input  logic                 DECOUPLE,
   input  logic [31:0]          meas_cmd,
   input  logic [31:0]          meas_mode,
   input  logic [31:0]          meas_time,
   input  logic [31:0]          meas_readouts,
   input  logic [31:0]          meas_heatup,
   input  logic [31:0]          meas_cooldown,
   input  logic                 transfer_en,
   input  logic [CNT_WIDTH-1:0] cnt_value,
   output logic                 ro_enable,
   output logic                 cnt_clear,
   output logic                 cnt_gate,
   output logic                 data_en,
   output logic [CNT_WIDTH-1:0] data_out,
   output logic                 transfer_active,
   output logic                 meas_done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_HEAT   = 3'd1,
      S_CLEAR  = 3'd2,
      S_GATE   = 3'd3,
      S_SETTLE = 3'd4,
      S_XFER   = 3'd5,
      S_COOL   = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);

   state_t      state_r;
   state_t      nxt_state_s;
   logic [31:0] cnt_r;
   logic [31:0] nxt_cnt_s;
   logic [31:0] rd_cnt_r;
   logic        mode_r;
   logic [31:0] time_r;
   logic [31:0] readouts_r;
   logic [31:0] heatup_r;
   logic [31:0] cooldown_r;
   logic        cmd0_q_r;
   logic        arm_r;

   logic        abort_s;
   logic        start_s;
   logic        load_s;
   logic        consume_s;
   logic        capture_s;
   logic        rearm_heat_s;
   logic        unused_bits_s;

   assign abort_s      = meas_cmd[1] | DECOUPLE;
   // arm_r keeps a start level held across reset from looking like a fresh edge
   assign start_s      = meas_cmd[0] & ~cmd0_q_r & arm_r & ~abort_s;
   assign rearm_heat_s = ~mode_r & (heatup_r != 32'd0);
   assign unused_bits_s = ^{meas_cmd[31:2], meas_mode[31:1]};

   // Next-state and down-counter reload logic
   always_comb begin
      nxt_state_s = state_r;
      nxt_cnt_s   = cnt_r;
      load_s      = 1'b0;
      consume_s   = 1'b0;
      capture_s   = 1'b0;
      if (abort_s) begin
         nxt_state_s = S_IDLE;
         nxt_cnt_s   = 32'd0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start_s) begin
                  load_s = 1'b1;
                  if (meas_readouts == 32'd0) begin
                     nxt_state_s = S_DONE;
                  end else if (meas_heatup != 32'd0) begin
                     nxt_state_s = S_HEAT;
                     nxt_cnt_s   = meas_heatup - 32'd1;
                  end else begin
                     nxt_state_s = S_CLEAR;
                  end
               end else begin
                  nxt_state_s = state_r;
               end
            end
            S_HEAT: begin
               if (cnt_r == 32'd0) begin
                  nxt_state_s = S_CLEAR;
               end else begin
                  nxt_cnt_s = cnt_r - 32'd1;
               end
            end
            S_CLEAR: begin
               nxt_state_s = S_GATE;
               nxt_cnt_s   = (time_r == 32'd0) ? 32'd0 : time_r - 32'd1;
            end
            S_GATE: begin
               if (cnt_r == 32'd0) begin
                  nxt_state_s = S_SETTLE;
                  nxt_cnt_s   = SETTLE_LOAD;
               end else begin
                  nxt_cnt_s = cnt_r - 32'd1;
               end
            end
            S_SETTLE: begin
               if (cnt_r == 32'd0) begin
                  nxt_state_s = S_XFER;
                  capture_s   = 1'b1;
               end else begin
                  nxt_cnt_s = cnt_r - 32'd1;
               end
            end
            S_XFER: begin
               if (transfer_en) begin
                  consume_s = 1'b1;
                  if (cooldown_r != 32'd0) begin
                     nxt_state_s = S_COOL;
                     nxt_cnt_s   = cooldown_r - 32'd1;
                  end else if ((rd_cnt_r + 32'd1) < readouts_r) begin
                     nxt_state_s = rearm_heat_s ? S_HEAT : S_CLEAR;
                     nxt_cnt_s   = rearm_heat_s ? heatup_r - 32'd1 : cnt_r;
                  end else begin
                     nxt_state_s = S_DONE;
                  end
               end else begin
                  nxt_state_s = S_XFER;
               end
            end
            S_COOL: begin
               if (cnt_r != 32'd0) begin
                  nxt_cnt_s = cnt_r - 32'd1;
               end else if (rd_cnt_r < readouts_r) begin
                  nxt_state_s = rearm_heat_s ? S_HEAT : S_CLEAR;
                  nxt_cnt_s   = rearm_heat_s ? heatup_r - 32'd1 : cnt_r;
               end else begin
                  nxt_state_s = S_DONE;
               end
            end
            default: begin
               nxt_state_s = S_IDLE;
               nxt_cnt_s   = 32'd0;
            end
         endcase
      end
   end

   // State, shadow parameters, counters and registered outputs
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         state_r         <= S_IDLE;
         cnt_r           <= 32'd0;
         rd_cnt_r        <= 32'd0;
         mode_r          <= 1'b0;
         time_r          <= 32'd0;
         readouts_r      <= 32'd0;
         heatup_r        <= 32'd0;
         cooldown_r      <= 32'd0;
         cmd0_q_r        <= 1'b0;
         arm_r           <= 1'b0;
         ro_enable       <= 1'b0;
         cnt_clear       <= 1'b0;
         cnt_gate        <= 1'b0;
         data_en         <= 1'b0;
         data_out        <= {CNT_WIDTH{1'b0}};
         transfer_active <= 1'b0;
         meas_done       <= 1'b0;
      end else begin
         cmd0_q_r <= meas_cmd[0];
         arm_r    <= arm_r | ~meas_cmd[0];
         state_r  <= nxt_state_s;
         cnt_r    <= nxt_cnt_s;
         if (load_s) begin
            mode_r     <= meas_mode[0];
            time_r     <= meas_time;
            readouts_r <= meas_readouts;
            heatup_r   <= meas_heatup;
            cooldown_r <= meas_cooldown;
            rd_cnt_r   <= 32'd0;
         end else if (consume_s) begin
            rd_cnt_r <= rd_cnt_r + 32'd1;
         end else begin
            rd_cnt_r <= rd_cnt_r;
         end
         if (abort_s) begin
            data_out <= {CNT_WIDTH{1'b0}};
         end else if (capture_s) begin
            data_out <= cnt_value;
         end else begin
            data_out <= data_out;
         end
         ro_enable       <= (nxt_state_s == S_HEAT) || (nxt_state_s == S_CLEAR) ||
                            (nxt_state_s == S_GATE) || (nxt_state_s == S_SETTLE);
         cnt_clear       <= (nxt_state_s == S_CLEAR);
         cnt_gate        <= (nxt_state_s == S_GATE);
         data_en         <= (nxt_state_s == S_XFER);
         transfer_active <= (nxt_state_s != S_IDLE) && (nxt_state_s != S_DONE);
         meas_done       <= (nxt_state_s == S_DONE);
      end
   end

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Directed bench for ro_meas_sequencer with a gated counter stub and a
// negedge activity monitor that tallies per-phase cycle counts.
module tb_ro_meas_sequencer;

   logic        CLK = 1'b0;
   logic        RESETN;
   logic        DECOUPLE;
   logic [31:0] meas_cmd;
   logic [31:0] meas_mode;
   logic [31:0] meas_time;
   logic [31:0] meas_readouts;
   logic [31:0] meas_heatup;
   logic [31:0] meas_cooldown;
   logic        transfer_en;
   logic [31:0] cnt_value;
   logic        ro_enable;
   logic        cnt_clear;
   logic        cnt_gate;
   logic        data_en;
   logic [31:0] data_out;
   logic        transfer_active;
   logic        meas_done;

   int checks   = 0;
   int failures = 0;

   ro_meas_sequencer #(.CNT_WIDTH(32), .SETTLE_CYCLES(4)) dut (
      .CLK(CLK), .RESETN(RESETN), .DECOUPLE(DECOUPLE),
      .meas_cmd(meas_cmd), .meas_mode(meas_mode), .meas_time(meas_time),
      .meas_readouts(meas_readouts), .meas_heatup(meas_heatup),
      .meas_cooldown(meas_cooldown), .transfer_en(transfer_en),
      .cnt_value(cnt_value), .ro_enable(ro_enable), .cnt_clear(cnt_clear),
      .cnt_gate(cnt_gate), .data_en(data_en), .data_out(data_out),
      .transfer_active(transfer_active), .meas_done(meas_done)
   );

   always #5 CLK = ~CLK;

   // Counter stub: counts clock cycles while gated
   always @(posedge CLK or negedge RESETN) begin
      if (!RESETN)        cnt_value <= 32'd0;
      else if (cnt_clear) cnt_value <= 32'd0;
      else if (cnt_gate)  cnt_value <= cnt_value + 32'd1;
   end

   logic        mon_clr = 1'b1;
   logic        post_gate, prev_heat, prev_den;
   logic [31:0] prev_data, last_data;
   int c_heat, c_heat_runs, c_clear, c_gate, c_settle, c_den, c_words, c_cool, c_active, c_word_err;
   wire heat_now = ro_enable & ~cnt_clear & ~cnt_gate & ~post_gate;

   // Phase activity monitor, sampled mid-cycle
   always @(negedge CLK) begin
      if (mon_clr) begin
         c_heat <= 0; c_heat_runs <= 0; c_clear <= 0; c_gate <= 0; c_settle <= 0;
         c_den <= 0; c_words <= 0; c_cool <= 0; c_active <= 0; c_word_err <= 0;
         post_gate <= 1'b0; prev_heat <= 1'b0; prev_den <= 1'b0;
         prev_data <= 32'd0; last_data <= 32'd0;
      end else begin
         c_heat   <= c_heat + (heat_now ? 1 : 0);
         if (heat_now && !prev_heat) c_heat_runs <= c_heat_runs + 1;
         prev_heat <= heat_now;
         c_clear  <= c_clear + (cnt_clear ? 1 : 0);
         c_gate   <= c_gate + (cnt_gate ? 1 : 0);
         c_settle <= c_settle + ((ro_enable & ~cnt_clear & ~cnt_gate & post_gate) ? 1 : 0);
         if (cnt_gate) post_gate <= 1'b1;
         else if (cnt_clear || data_en) post_gate <= 1'b0;
         c_den    <= c_den + (data_en ? 1 : 0);
         if (data_en && transfer_en) begin
            c_words   <= c_words + 1;
            last_data <= data_out;
         end
         if (data_en && prev_den && (data_out != prev_data)) c_word_err <= c_word_err + 1;
         prev_den  <= data_en;
         prev_data <= data_out;
         c_cool   <= c_cool + ((transfer_active & ~ro_enable & ~data_en) ? 1 : 0);
         c_active <= c_active + (transfer_active ? 1 : 0);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      mon_clr = 1'b1;
      @(negedge CLK);
      #1;
      mon_clr = 1'b0;
   endtask

   task automatic start_job();
      meas_cmd = 32'd0;
      tick();
      meas_cmd = 32'd1;
      tick();
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (meas_done !== 1'b1 && n < 3000) begin tick(); n++; end
      chk({tag, "_done_timeout"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_den(input string tag);
      int n = 0;
      while (data_en !== 1'b1 && n < 3000) begin tick(); n++; end
      chk({tag, "_den_timeout"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic wait_gate(input string tag, input logic level);
      int n = 0;
      while (cnt_gate !== level && n < 3000) begin tick(); n++; end
      chk({tag, "_gate_timeout"}, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
   endtask

   task automatic set_job(input logic [31:0] heat, input logic [31:0] tm, input logic [31:0] rd,
                          input logic [31:0] cool, input logic [31:0] mode);
      meas_heatup = heat; meas_time = tm; meas_readouts = rd;
      meas_cooldown = cool; meas_mode = mode;
   endtask

   initial begin
      RESETN = 1'b0; DECOUPLE = 1'b0; meas_cmd = 32'd0; transfer_en = 1'b1;
      set_job(32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
      repeat (3) tick();
      chk("rst_outputs", {25'd0, ro_enable, cnt_clear, cnt_gate, data_en,
                          transfer_active, meas_done, 1'b0}, 32'd0);
      chk("rst_data_out", data_out, 32'd0);
      RESETN = 1'b1;
      tick();

      // Basic job
      set_job(32'd10, 32'd100, 32'd1, 32'd5, 32'd0);
      clear_mon();
      start_job();
      wait_done("basic");
      chk("basic_heat", c_heat, 32'd10);
      chk("basic_clear", c_clear, 32'd1);
      chk("basic_gate", c_gate, 32'd100);
      chk("basic_settle", c_settle, 32'd4);
      chk("basic_den", c_den, 32'd1);
      chk("basic_words", c_words, 32'd1);
      chk("basic_data", last_data, 32'd100);
      chk("basic_cool", c_cool, 32'd5);
      chk("basic_active", c_active, 32'd121);
      chk("basic_den_low", {31'd0, data_en}, 32'd0);

      // Repeats, mode 0 (parameter change mid-job must not matter)
      set_job(32'd4, 32'd6, 32'd3, 32'd2, 32'd0);
      clear_mon();
      start_job();
      meas_time = 32'd50;
      wait_done("rep0");
      chk("rep0_heat_runs", c_heat_runs, 32'd3);
      chk("rep0_heat", c_heat, 32'd12);
      chk("rep0_gate", c_gate, 32'd18);
      chk("rep0_words", c_words, 32'd3);
      chk("rep0_data", last_data, 32'd6);
      chk("rep0_cool", c_cool, 32'd6);
      chk("rep0_active", c_active, 32'd54);

      // Repeats, mode 1
      set_job(32'd4, 32'd6, 32'd3, 32'd2, 32'd1);
      clear_mon();
      start_job();
      wait_done("rep1");
      chk("rep1_heat_runs", c_heat_runs, 32'd1);
      chk("rep1_heat", c_heat, 32'd4);
      chk("rep1_words", c_words, 32'd3);
      chk("rep1_clear", c_clear, 32'd3);
      chk("rep1_active", c_active, 32'd46);

      // Backpressure
      set_job(32'd0, 32'd3, 32'd1, 32'd0, 32'd0);
      transfer_en = 1'b0;
      clear_mon();
      start_job();
      wait_den("bp");
      repeat (20) tick();
      chk("bp_den_held", {31'd0, data_en}, 32'd1);
      chk("bp_data_held", data_out, 32'd3);
      transfer_en = 1'b1;
      tick();
      chk("bp_den_drop", {31'd0, data_en}, 32'd0);
      chk("bp_done", {31'd0, meas_done}, 32'd1);
      chk("bp_den_cycles", c_den, 32'd21);
      chk("bp_words", c_words, 32'd1);
      chk("bp_word_stable", c_word_err, 32'd0);

      // Zero heat/time/cool
      set_job(32'd0, 32'd0, 32'd1, 32'd0, 32'd0);
      clear_mon();
      start_job();
      wait_done("zero");
      chk("zero_heat", c_heat, 32'd0);
      chk("zero_gate", c_gate, 32'd1);
      chk("zero_cool", c_cool, 32'd0);
      chk("zero_data", last_data, 32'd1);
      chk("zero_active", c_active, 32'd7);

      // Zero readouts
      set_job(32'd3, 32'd5, 32'd0, 32'd2, 32'd0);
      clear_mon();
      start_job();
      chk("nord_done", {31'd0, meas_done}, 32'd1);
      chk("nord_active", {31'd0, transfer_active}, 32'd0);
      repeat (3) tick();
      chk("nord_den", c_den, 32'd0);

      // Simultaneous start and abort from DONE
      meas_cmd = 32'd0;
      tick();
      meas_cmd = 32'd3;
      tick();
      chk("sa_active", {31'd0, transfer_active}, 32'd0);
      chk("sa_done", {31'd0, meas_done}, 32'd0);
      meas_cmd = 32'd0;

      // Abort mid-GATE
      set_job(32'd0, 32'd100, 32'd1, 32'd0, 32'd0);
      start_job();
      wait_gate("ab", 1'b1);
      repeat (10) tick();
      meas_cmd = 32'd3;
      tick();
      chk("ab_outputs", {26'd0, ro_enable, cnt_clear, cnt_gate, data_en,
                         transfer_active, meas_done}, 32'd0);
      meas_cmd = 32'd0;
      tick();
      chk("ab_stays_idle", {31'd0, transfer_active}, 32'd0);

      // DECOUPLE mid-XFER, then start ignored while decoupled
      set_job(32'd0, 32'd5, 32'd1, 32'd0, 32'd0);
      transfer_en = 1'b0;
      start_job();
      wait_den("dc");
      DECOUPLE = 1'b1;
      tick();
      chk("dc_den", {31'd0, data_en}, 32'd0);
      chk("dc_data", data_out, 32'd0);
      chk("dc_done", {31'd0, meas_done}, 32'd0);
      start_job();
      chk("dc_start_ignored", {31'd0, transfer_active}, 32'd0);
      DECOUPLE = 1'b0;
      transfer_en = 1'b1;

      // Fresh job after aborts, with an ignored restart mid-job
      clear_mon();
      start_job();
      wait_gate("fr", 1'b1);
      start_job();
      wait_done("fr");
      chk("fr_words", c_words, 32'd1);
      chk("fr_data", last_data, 32'd5);
      chk("fr_active", c_active, 32'd11);

      // Async reset mid-SETTLE
      set_job(32'd0, 32'd5, 32'd1, 32'd3, 32'd0);
      start_job();
      wait_gate("ar", 1'b1);
      wait_gate("ar", 1'b0);
      chk("ar_in_settle", {31'd0, ro_enable}, 32'd1);
      #2;
      RESETN = 1'b0;
      #1;
      chk("ar_outputs", {26'd0, ro_enable, cnt_clear, cnt_gate, data_en,
                         transfer_active, meas_done}, 32'd0);
      tick();
      #2;
      RESETN = 1'b1;
      repeat (5) tick();
      chk("ar_held_start_ignored", {31'd0, transfer_active}, 32'd0);
      clear_mon();
      start_job();
      wait_done("ar");
      chk("ar_words", c_words, 32'd1);
      chk("ar_data", last_data, 32'd5);
      chk("ar_cool", c_cool, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ro_meas_sequencer.md
Name: ro_meas_sequencer

Overview:
Measurement controller between the PS-side register block (meas_* / transfer_* signals) and the ring-oscillator array and counter datapath. It runs one measurement job per start command: heat-up, a gated count window, counter settle, readout word handshake and cool-down. The sequence repeats meas_readouts times, then the block flags meas_done. It aborts cleanly on command or on partial-reconfiguration decouple.

Parameters:
CNT_WIDTH, 32, width of the counter value and of data_out
SETTLE_CYCLES, 4, wait cycles after the gate closes before cnt_value is sampled (counter CDC/pipeline depth); legal range 1..255

Ports:
CLK  in  1  system clock (sys_clk0 domain)
RESETN  in  1  asynchronous active-low reset
DECOUPLE  in  1  PR decouple; high forces abort, start ignored while high
meas_cmd  in  32  bit0 start (rising edge), bit1 abort (level), others ignored
meas_mode  in  32  bit0: 0 = heat-up before every readout, 1 = heat-up before first readout only
meas_time  in  32  gate window length in cycles; 0 treated as 1
meas_readouts  in  32  readouts per job; 0 = no readouts
meas_heatup  in  32  heat-up cycles; 0 skips heat-up
meas_cooldown  in  32  cool-down cycles after each readout; 0 skips cool-down
transfer_en  in  1  sink ready for a data word
cnt_value  in  CNT_WIDTH  counter result from the datapath
ro_enable  out  1  oscillators running
cnt_clear  out  1  one-cycle counter clear pulse
cnt_gate  out  1  counter gate
data_en  out  1  data_out valid
data_out  out  CNT_WIDTH  captured count
transfer_active  out  1  job in progress
meas_done  out  1  job complete (level)

Behaviour:
- Reset (async, RESETN low): state IDLE. All outputs 0, including data_out. Internal counters 0. The start-edge register is also 0.
- Parameters are latched into shadow registers on the start edge; later changes have no effect on a running job.
- start_edge = meas_cmd[0] & ~meas_cmd0_q. It is accepted only in IDLE or DONE and only when DECOUPLE=0 and meas_cmd[1]=0.
- States:
  - IDLE: waits for start_edge.
  - HEAT: ro_enable=1 for heatup cycles.
  - CLEAR: 1 cycle with cnt_clear=1 and ro_enable=1.
  - GATE: cnt_gate=1 for exactly max(meas_time,1) consecutive cycles.
  - SETTLE: SETTLE_CYCLES cycles with gate low; on the last cycle cnt_value is registered into data_out.
  - XFER: data_en=1 and data_out held stable until a cycle with transfer_en=1. The word is consumed on that edge and data_en drops the next cycle. With transfer_en already high, data_en is high for exactly 1 cycle.
  - COOL: ro_enable=0 for cooldown cycles.
  - DONE: meas_done=1.
- Transitions:
  - IDLE→HEAT on start; HEAT is skipped (→CLEAR) if heatup=0.
  - If readouts=0, start goes IDLE→DONE directly with no data words.
  - After each word, readout counter increments; XFER→COOL (or skip COOL if cooldown=0).
  - After COOL: if more readouts remain → HEAT (mode0=0) or CLEAR (mode0=1); else → DONE.
  - DONE→HEAT/CLEAR/DONE on a new start_edge; meas_done clears on that same edge.
- transfer_active=1 in all states except IDLE and DONE.
- ro_enable=1 in HEAT, CLEAR, GATE and SETTLE. It is also 1 in HEAT-skipped paths from CLEAR onward. It is 0 in XFER, COOL, IDLE and DONE.
- Cycle counters are 32-bit down-counters loaded on state entry; there is no wrap. A 32-bit readout counter compares against the latched readouts value.
- Abort: meas_cmd[1]=1 or DECOUPLE=1 in any state →IDLE on the next edge. All outputs drop to 0 and meas_done stays 0; a pending word is discarded.
- Simultaneous start and abort: abort wins.
- A start edge during a running job is ignored, not queued.
- Reset mid-job has the same output effect as abort.

Test Plan:
- Basic job: heatup=10, time=100, readouts=1, cooldown=5, mode=0, transfer_en=1, counter stub counts while gated → ro_enable high for 10 cycles before cnt_clear. cnt_gate is high for exactly 100 cycles. One data_en pulse carries data_out=100. meas_done rises 5 cycles after the pulse.
- Repeats: readouts=3, mode=0 vs mode=1 → 3 words each. HEAT occurs 3 times in mode 0 and once in mode 1; waveform cycle counts match.
- Backpressure: transfer_en low for 20 cycles at XFER → data_en held 20+ cycles with data_out constant. The word is consumed on the first transfer_en=1 edge and there are no duplicates.
- Zero values: heatup=0, time=0, cooldown=0 → no HEAT/COOL cycles and the gate is 1 cycle. With readouts=0, meas_done rises 1 cycle after start with no data_en.
- Abort: assert meas_cmd[1] mid-GATE, then separately DECOUPLE mid-XFER → all outputs 0 the next cycle and meas_done=0. A fresh start then runs a full job correctly.
- Async reset: RESETN low mid-SETTLE between clock edges → outputs 0 immediately. After release, the block ignores meas_cmd[0] held high until a new 0→1 edge.
